ps2_key_decoder: RTL and testbench

- Converts the raw PS/2 byte stream from the receiver into per-player game commands: 3-bit direction, bomb and start pulses, and valid strobes.
- Upstream: the PS/2 receiver (byte plus one-cycle done tick). Downstream: the game controller and option/menu logic.
- Decodes E0 (extended) and F0 (break) prefixes and tracks held keys, so typematic auto-repeat does not create extra commands.
- Runs on the 50 MHz system clock, the same domain as the receiver.

---
 rtl/ps2_key_decoder_if.sv | 26 ++
 rtl/ps2_key_decoder.sv | 174 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / command-out bundle between the PS/2 receiver, the key decoder
// and the game/menu logic.
interface ps2_key_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_done_tick;
    logic [2:0]  direction_1;
    logic [2:0]  direction_2;
    logic        bomb_1;
    logic        bomb_2;
    logic        out_valid_1;
    logic        out_valid_2;
    logic        start;
    logic [10:0] held_o;

    modport master (
        output rx_data, rx_done_tick,
        input  direction_1, direction_2, bomb_1, bomb_2,
        input  out_valid_1, out_valid_2, start, held_o
    );

    modport slave (
        input  rx_data, rx_done_tick,
        output direction_1, direction_2, bomb_1, bomb_2,
        output out_valid_1, out_valid_2, start, held_o
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream to per-player game commands with E0/F0 prefix handling.
// Define PS2_KEY_REPEAT_EN to re-issue a held direction every REPEAT_CYCLES.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int REPEAT_CYCLES  = 10_000_000
) (
    input logic             clk,
    input logic             rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t         state;
    logic [TW-1:0]  tcount;
    logic [10:0]    held;
    logic [2:0]     dir_1, dir_2;
    logic           bomb_1, bomb_2, valid_1, valid_2, start;

    logic           key_ext, key_hit, is_prefix, make_ev, break_ev, player_2;
    logic [3:0]     key_idx, slot;
    logic [2:0]     dir_code;

    // Held-bitmap index of a (extended, code) pair; bit 4 of the result flags a hit.
    function automatic logic [4:0] lookup(input logic ext, input logic [7:0] code);
        logic [4:0] r;
        r = 5'd0;
        if (!ext) begin
            case (code)
                8'h1D: r = {1'b1, 4'd0};
                8'h1B: r = {1'b1, 4'd1};
                8'h1C: r = {1'b1, 4'd2};
                8'h23: r = {1'b1, 4'd3};
                8'h29: r = {1'b1, 4'd4};
                8'h5A: r = {1'b1, 4'd10};
                default: r = 5'd0;
            endcase
        end else begin
            case (code)
                8'h75: r = {1'b1, 4'd5};
                8'h72: r = {1'b1, 4'd6};
                8'h6B: r = {1'b1, 4'd7};
                8'h74: r = {1'b1, 4'd8};
                8'h14: r = {1'b1, 4'd9};
                default: r = 5'd0;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        key_ext   = (state == EXT) || (state == EXT_BRK);
        {key_hit, key_idx} = lookup(key_ext, bus.rx_data);
        is_prefix = (bus.rx_data == 8'hE0) || (bus.rx_data == 8'hF0);
        make_ev   = bus.rx_done_tick &&
                    (((state == IDLE) && !is_prefix) || ((state == EXT) && (bus.rx_data != 8'hF0)));
        break_ev  = bus.rx_done_tick && ((state == BRK) || (state == EXT_BRK)) && !is_prefix;
        player_2  = (key_idx >= 4'd5) && (key_idx <= 4'd9);
        slot      = player_2 ? (key_idx - 4'd5) : key_idx;
        dir_code  = slot[2:0] + 3'd1;
    end

`ifdef PS2_KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep_1, rep_2;
`else
    logic unused_repeat;
    assign unused_repeat = (REPEAT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tcount  <= '0;
            held    <= '0;
            dir_1   <= 3'd0;
            dir_2   <= 3'd0;
            bomb_1  <= 1'b0;
            bomb_2  <= 1'b0;
            valid_1 <= 1'b0;
            valid_2 <= 1'b0;
            start   <= 1'b0;
`ifdef PS2_KEY_REPEAT_EN
            rep_1   <= '0;
            rep_2   <= '0;
`endif
        end else begin
            bomb_1  <= 1'b0;
            bomb_2  <= 1'b0;
            valid_1 <= 1'b0;
            valid_2 <= 1'b0;
            start   <= 1'b0;

`ifdef PS2_KEY_REPEAT_EN
            // Auto-repeat runs first so a same-cycle make or break overrides it below.
            if (dir_1 == 3'd0) rep_1 <= '0;
            else if (rep_1 == RW'(REPEAT_CYCLES - 1)) begin
                rep_1   <= '0;
                valid_1 <= 1'b1;
            end else rep_1 <= rep_1 + 1'b1;

            if (dir_2 == 3'd0) rep_2 <= '0;
            else if (rep_2 == RW'(REPEAT_CYCLES - 1)) begin
                rep_2   <= '0;
                valid_2 <= 1'b1;
            end else rep_2 <= rep_2 + 1'b1;
`endif

            if (bus.rx_done_tick) begin
                tcount <= '0;
                case (state)
                    IDLE:    state <= (bus.rx_data == 8'hE0) ? EXT :
                                      (bus.rx_data == 8'hF0) ? BRK : IDLE;
                    EXT:     state <= (bus.rx_data == 8'hF0) ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                    state  <= IDLE;
                    tcount <= '0;
                end else tcount <= tcount + 1'b1;
            end

            // Only the first make of a key counts; typematic repeats find the bit already set.
            if (make_ev && key_hit && !held[key_idx]) begin
                held[key_idx] <= 1'b1;
                if (key_idx == 4'd10) start <= 1'b1;
                else if (!player_2) begin
                    valid_1 <= 1'b1;
                    if (slot == 4'd4) bomb_1 <= 1'b1;
                    else begin
                        dir_1 <= dir_code;
`ifdef PS2_KEY_REPEAT_EN
                        rep_1 <= '0;
`endif
                    end
                end else begin
                    valid_2 <= 1'b1;
                    if (slot == 4'd4) bomb_2 <= 1'b1;
                    else begin
                        dir_2 <= dir_code;
`ifdef PS2_KEY_REPEAT_EN
                        rep_2 <= '0;
`endif
                    end
                end
            end

            if (break_ev && key_hit && held[key_idx]) begin
                held[key_idx] <= 1'b0;
                if (key_idx != 4'd10 && slot != 4'd4) begin
                    if (!player_2 && dir_1 == dir_code) begin
                        dir_1   <= 3'd0;
                        valid_1 <= 1'b0;
                    end
                    if (player_2 && dir_2 == dir_code) begin
                        dir_2   <= 3'd0;
                        valid_2 <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.direction_1 = dir_1;
    assign bus.direction_2 = dir_2;
    assign bus.bomb_1      = bomb_1;
    assign bus.bomb_2      = bomb_2;
    assign bus.out_valid_1 = valid_1;
    assign bus.out_valid_2 = valid_2;
    assign bus.start       = start;
    assign bus.held_o      = held;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; the auto-repeat section is built only
// when PS2_KEY_REPEAT_EN is defined.
module tb_ps2_key_decoder;
    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    int   valid1Count;
    int   valid2Count;
    int   bomb1Count;
    int   snap;

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(20),
        .REPEAT_CYCLES (100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters let multi-byte sequences be checked for stray pulses.
    always @(negedge clk) begin
        if (bus.out_valid_1) valid1Count++;
        if (bus.out_valid_2) valid2Count++;
        if (bus.bomb_1)      bomb1Count++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        @(negedge clk);
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        valid1Count = 0;
        valid2Count = 0;
        bomb1Count  = 0;
        bus.rx_data      = 8'h00;
        bus.rx_done_tick = 1'b0;
        rst_n = 1'b0;
        idle(3);
        checkOutput("reset dir1", int'(bus.direction_1), 0);
        checkOutput("reset dir2", int'(bus.direction_2), 0);
        checkOutput("reset held", int'(bus.held_o), 0);
        checkOutput("reset strobes", int'({bus.out_valid_1, bus.out_valid_2, bus.bomb_1, bus.bomb_2, bus.start}), 0);
        rst_n = 1'b1;
        idle(2);

        applyStimulus(8'h1D);
        checkOutput("W make dir1", int'(bus.direction_1), 1);
        checkOutput("W make valid1", int'(bus.out_valid_1), 1);
        checkOutput("W make held", int'(bus.held_o), 11'h001);
        idle(1);
        checkOutput("W valid1 one cycle", int'(bus.out_valid_1), 0);
        applyStimulus(8'hF0);
        applyStimulus(8'h1D);
        checkOutput("W break dir1", int'(bus.direction_1), 0);
        checkOutput("W break no valid", int'(bus.out_valid_1), 0);
        checkOutput("W break held", int'(bus.held_o), 0);

        applyStimulus(8'hE0);
        applyStimulus(8'h6B);
        checkOutput("left2 dir2", int'(bus.direction_2), 3);
        checkOutput("left2 valid2", int'(bus.out_valid_2), 1);
        checkOutput("left2 held", int'(bus.held_o), 11'h080);
        idle(1);
        snap = valid2Count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'hE0);
            applyStimulus(8'h6B);
        end
        idle(1);
        checkOutput("left2 typematic strobes", valid2Count - snap, 0);
        checkOutput("left2 typematic dir2", int'(bus.direction_2), 3);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h6B);
        checkOutput("left2 break dir2", int'(bus.direction_2), 0);
        checkOutput("left2 break held", int'(bus.held_o), 0);

        applyStimulus(8'h29);
        checkOutput("bomb1 pulse", int'(bus.bomb_1), 1);
        checkOutput("bomb1 valid1", int'(bus.out_valid_1), 1);
        idle(1);
        checkOutput("bomb1 one cycle", int'({bus.bomb_1, bus.out_valid_1}), 0);
        snap = bomb1Count;
        applyStimulus(8'h29);
        idle(1);
        checkOutput("bomb1 repeat no pulse", bomb1Count - snap, 0);
        applyStimulus(8'hF0);
        applyStimulus(8'h29);
        applyStimulus(8'h29);
        checkOutput("bomb1 re-press pulse", int'(bus.bomb_1), 1);
        applyStimulus(8'hF0);
        applyStimulus(8'h29);
        checkOutput("bomb1 released held", int'(bus.held_o), 0);

        snap = valid2Count;
        applyStimulus(8'hE0);
        idle(25);
        applyStimulus(8'h1C);
        checkOutput("timeout dir1", int'(bus.direction_1), 3);
        checkOutput("timeout dir2", int'(bus.direction_2), 0);
        checkOutput("timeout held", int'(bus.held_o), 11'h004);
        checkOutput("timeout no P2 event", valid2Count - snap, 0);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);

        applyStimulus(8'h1D);
        applyStimulus(8'h23);
        checkOutput("two dirs newest wins", int'(bus.direction_1), 4);
        checkOutput("two dirs held", int'(bus.held_o), 11'h009);
        applyStimulus(8'hF0);
        applyStimulus(8'h1D);
        checkOutput("older release keeps dir", int'(bus.direction_1), 4);
        applyStimulus(8'hF0);
        applyStimulus(8'h23);
        checkOutput("newer release clears dir", int'(bus.direction_1), 0);
        applyStimulus(8'h5A);
        checkOutput("enter start", int'(bus.start), 1);
        checkOutput("enter held", int'(bus.held_o), 11'h400);
        idle(1);
        checkOutput("start one cycle", int'(bus.start), 0);
        applyStimulus(8'hF0);
        applyStimulus(8'h5A);

        applyStimulus(8'h1D);
        applyStimulus(8'hF0);
        rst_n = 1'b0;
        idle(2);
        checkOutput("mid-seq reset dir1", int'(bus.direction_1), 0);
        checkOutput("mid-seq reset held", int'(bus.held_o), 0);
        rst_n = 1'b1;
        idle(1);
        applyStimulus(8'h1B);
        checkOutput("post-reset make dir1", int'(bus.direction_1), 2);
        checkOutput("post-reset make valid1", int'(bus.out_valid_1), 1);
        applyStimulus(8'hF0);
        applyStimulus(8'h1B);
        checkOutput("post-reset break dir1", int'(bus.direction_1), 0);

`ifdef PS2_KEY_REPEAT_EN
        idle(2);
        snap = valid1Count;
        applyStimulus(8'h1B);
        checkOutput("repeat press valid1", int'(bus.out_valid_1), 1);
        idle(99);
        checkOutput("repeat before +100", int'(bus.out_valid_1), 0);
        idle(1);
        checkOutput("repeat at +100", int'(bus.out_valid_1), 1);
        idle(100);
        checkOutput("repeat at +200", int'(bus.out_valid_1), 1);
        idle(100);
        checkOutput("repeat at +300", int'(bus.out_valid_1), 1);
        checkOutput("repeat dir1 kept", int'(bus.direction_1), 2);
        idle(48);
        applyStimulus(8'hF0);
        applyStimulus(8'h1B);
        idle(150);
        checkOutput("repeat total pulses", valid1Count - snap, 4);
        checkOutput("repeat released dir1", int'(bus.direction_1), 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
